// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: ROWS x COLS active-low matrix keypad scanner with
// per-key debounce and a first-word-fall-through press/release event FIFO.
// Ports: clk, rstn (async active-low), col_drv (one column low per slot),
//   row_in (active-low rows), ev_valid/ev_ready/ev_code/ev_press (event out),
//   key_map (debounced key state), overflow (pulse on dropped event).
// Optional feature: define KEYPAD_REPEAT_EN for typematic repeat press events
//   while exactly one key is held (REPEAT_DELAY / REPEAT_RATE in full scans).
module keypad_matrix_scanner #(
    parameter int COLS       = 5,
    parameter int ROWS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 8,
    parameter int FIFO_DEPTH = 4,
`ifdef KEYPAD_REPEAT_EN
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8,
`endif
    localparam int CODE_W = $clog2(COLS*ROWS)
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic [COLS-1:0]      col_drv,
    input  logic [ROWS-1:0]      row_in,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [CODE_W-1:0]    ev_code,
    output logic                 ev_press,
    output logic [COLS*ROWS-1:0] key_map,
    output logic                 overflow
);
    localparam int KEYS   = COLS*ROWS;
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW     = $clog2(SCAN_DIV);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int SMP_AT = SCAN_DIV - ROWS - 1;
    localparam int EV_AT  = SCAN_DIV - ROWS;

    logic [SW-1:0]   slot_cnt;
    logic [CW-1:0]   col_idx;
    logic [ROWS-1:0] row_smp;
    logic [3:0]      db_cnt [KEYS];

    logic              eval;
    logic [RW-1:0]     row_sel;
    logic [CODE_W-1:0] key_idx;
    logic              smp_bit;
    logic              cur_bit;
    logic              flip;

    logic              push;
    logic [CODE_W:0]   push_ev;

    // Rows are evaluated one per cycle in the last ROWS cycles of a slot.
    assign eval    = slot_cnt >= SW'(EV_AT);
    assign row_sel = RW'(slot_cnt - SW'(EV_AT));
    assign key_idx = eval ? CODE_W'(int'(col_idx)*ROWS + int'(row_sel)) : '0;
    assign smp_bit = row_smp[row_sel];
    assign cur_bit = key_map[key_idx];
    assign flip    = eval && (smp_bit != cur_bit)
                  && (db_cnt[key_idx] == 4'(DEBOUNCE-1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_cnt <= '0;
            col_idx  <= '0;
            col_drv  <= '1;
            row_smp  <= '0;
        end else begin
            col_drv <= ~(COLS'(1) << col_idx);
            if (slot_cnt == SW'(SCAN_DIV-1)) begin
                slot_cnt <= '0;
                col_idx  <= (col_idx == CW'(COLS-1)) ? '0 : col_idx + CW'(1);
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
            // Late sample leaves the column drive time to settle.
            if (slot_cnt == SW'(SMP_AT))
                row_smp <= ~row_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_map <= '0;
            for (int k = 0; k < KEYS; k++)
                db_cnt[k] <= '0;
        end else if (eval) begin
            if (smp_bit == cur_bit || flip)
                db_cnt[key_idx] <= '0;
            else
                db_cnt[key_idx] <= db_cnt[key_idx] + 4'd1;
            if (flip)
                key_map[key_idx] <= smp_bit;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [7:0]        rep_cnt;
    logic              rep_first;
    logic              single;
    logic              scan_tick;
    logic              rep_push;
    logic [CODE_W-1:0] held_code;

    assign single = (key_map != '0)
                 && ((key_map & (key_map - KEYS'(1))) == '0);

    always_comb begin
        held_code = '0;
        for (int k = 0; k < KEYS; k++)
            if (key_map[k])
                held_code = CODE_W'(k);
    end

    // Slot 0 of column 0 never evaluates a key, so a repeat
    // push can never collide with a debounce push.
    assign scan_tick = (slot_cnt == '0) && (col_idx == '0);
    assign rep_push  = scan_tick && single && (rep_cnt ==
        (rep_first ? 8'(REPEAT_DELAY-1) : 8'(REPEAT_RATE-1)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (flip || !single) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (scan_tick) begin
            if (rep_push) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 8'd1;
            end
        end
    end

    assign push    = flip | rep_push;
    assign push_ev = flip ? {smp_bit, key_idx} : {1'b1, held_code};
`else
    assign push    = flip;
    assign push_ev = {smp_bit, key_idx};
`endif

    logic [CODE_W:0] mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [CODE_W:0] last_ev;
    logic            full;
    logic            pop;
    logic            do_push;

    assign ev_valid = count != '0;
    assign full     = count == (PW+1)'(FIFO_DEPTH);
    assign pop      = ev_valid && ev_ready;
    assign do_push  = push && (!full || pop);
    // Outputs hold the last popped event while the FIFO is empty.
    assign {ev_press, ev_code} = ev_valid ? mem[rd_ptr] : last_ev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_ev  <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            overflow <= push && full && !pop;
            if (do_push) begin
                mem[wr_ptr] <= push_ev;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                last_ev <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PW'(1);
            end
            if (do_push && !pop)
                count <= count + (PW+1)'(1);
            else if (!do_push && pop)
                count <= count - (PW+1)'(1);
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed bench for keypad_matrix_scanner.
// A keypad model drives row_in from col_drv; events go through a scoreboard.
module tb_keypad_matrix_scanner;
    localparam int COLS = 5;
    localparam int ROWS = 4;
    localparam int SDIV = 8;
    localparam int SCAN = COLS*SDIV;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [4:0]  col_drv;
    logic [3:0]  row_in;
    logic        ev_valid;
    logic        ev_ready = 1'b1;
    logic [4:0]  ev_code;
    logic        ev_press;
    logic [19:0] key_map;
    logic        overflow;
    logic [19:0] pressed = '0;

    int n_checks = 0;
    int n_errors = 0;
    int ovf_cnt  = 0;
    int ovf0;
    logic [5:0] exp_q [$];
    logic [5:0] e;
    int bp_keys [5] = '{0, 5, 10, 15, 19};

    keypad_matrix_scanner #(
        .COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SDIV),
        .DEBOUNCE(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rstn(rstn), .col_drv(col_drv), .row_in(row_in),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_press(ev_press), .key_map(key_map), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Held key pulls its row low while its column is driven low.
    always_comb begin
        row_in = '1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (!col_drv[c] && pressed[c*ROWS+r])
                    row_in[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n*SCAN) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k, input logic p);
        pressed[k] = p;
        exp_q.push_back({p, 5'(k)});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (overflow) ovf_cnt++;
                if (rstn && ev_valid && ev_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_event: got code=%0d press=%0b expected none",
                                 ev_code, ev_press);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event", 32'({ev_press, ev_code}), 32'(e));
                    end
                end
            end
        join_none

        // Reset values and column walk
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_col_drv", 32'(col_drv), 32'h1f);
        chk("rst_ev_valid", 32'(ev_valid), 32'h0);
        chk("rst_ev_code", 32'(ev_code), 32'h0);
        chk("rst_ev_press", 32'(ev_press), 32'h0);
        chk("rst_key_map", 32'(key_map), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("col0_drv", 32'(col_drv), 32'h1e);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("col1_drv", 32'(col_drv), 32'h1d);

        // Key tap on key 12 (col3 row0)
        @(posedge clk); #1;
        press(12, 1'b1);
        wait_scans(4);
        chk("tap_key_map", 32'(key_map), 32'h01000);
        chk("tap_press_seen", 32'(exp_q.size()), 32'd0);
        press(12, 1'b0);
        wait_scans(4);
        chk("tap_rel_map", 32'(key_map), 32'h0);
        chk("tap_rel_seen", 32'(exp_q.size()), 32'd0);

        // One-scan glitch on key 6 (col1 row2)
        pressed[6] = 1'b1;
        repeat (SCAN) @(posedge clk);
        #1;
        pressed[6] = 1'b0;
        wait_scans(4);
        chk("bounce_key_map", 32'(key_map), 32'h0);

        // Backpressure: five presses, four fit
        ev_ready = 1'b0;
        ovf0 = ovf_cnt;
        for (int i = 0; i < 5; i++) begin
            pressed[bp_keys[i]] = 1'b1;
            if (i < 4) exp_q.push_back({1'b1, 5'(bp_keys[i])});
            wait_scans(4);
        end
        chk("bp_overflow_pulses", 32'(ovf_cnt - ovf0), 32'd1);
        chk("bp_key_map", 32'(key_map), 32'h88421);
        chk("bp_valid", 32'(ev_valid), 32'h1);
        chk("bp_head", 32'({ev_press, ev_code}), 32'h20);
        ev_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        chk("bp_empty", 32'(ev_valid), 32'h0);
        chk("bp_hold_last", 32'({ev_press, ev_code}), 32'h2f);
        for (int i = 0; i < 5; i++) begin
            press(bp_keys[i], 1'b0);
            wait_scans(4);
        end
        chk("bp_rel_seen", 32'(exp_q.size()), 32'd0);
        chk("bp_rel_map", 32'(key_map), 32'h0);

        // Reset with two queued events and key 12 held
        ev_ready = 1'b0;
        press(12, 1'b1);
        wait_scans(4);
        press(1, 1'b1);
        wait_scans(4);
        chk("mid_valid", 32'(ev_valid), 32'h1);
        chk("mid_key_map", 32'(key_map), 32'h01002);
        rstn = 1'b0;
        exp_q.delete();
        pressed[1] = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ev_valid), 32'h0);
        chk("mid_rst_key_map", 32'(key_map), 32'h0);
        chk("mid_rst_col_drv", 32'(col_drv), 32'h1f);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_q.push_back({1'b1, 5'd12});
        ev_ready = 1'b1;
        wait_scans(5);
        chk("mid_repress_map", 32'(key_map), 32'h01000);
        chk("mid_repress_seen", 32'(exp_q.size()), 32'd0);
        press(12, 1'b0);
        wait_scans(4);
        chk("mid_rel_seen", 32'(exp_q.size()), 32'd0);
        chk("mid_rel_map", 32'(key_map), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
